// File: rtl/uart_string_sender.sv
`default_nettype none
// ============================================================================
// Module   : uart_string_sender
// Purpose  : Sends a fixed message over a UART line on a button edge, with
//            optional parity, 1/2 stop bits and continuous repeat mode.
// Revision : 1.0  initial release
// ============================================================================
module uart_string_sender #(
    parameter int                   CLK_FREQ  = 1_000_000,
    parameter int                   BAUD      = 100_000,
    parameter int                   DATA_BITS = 8,
    parameter int                   PARITY    = 0,
    parameter int                   STOP_BITS = 1,
    parameter int                   MSG_LEN   = 2,
    parameter logic [MSG_LEN*8-1:0] MSG       = "Hi"
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           button,
    input  logic                           repeat_en,
    output logic                           tx,
    output logic                           busy,
    output logic                           done,
    output logic [$clog2(MSG_LEN+1)-1:0]   char_idx
);

    localparam int c_CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int c_STOP_CLKS    = STOP_BITS * c_CLKS_PER_BIT;
    localparam int c_CNT_W        = $clog2(c_STOP_CLKS + 1);
    localparam int c_IDX_W        = $clog2(MSG_LEN + 1);
    localparam int c_BIT_W        = $clog2(DATA_BITS);

    localparam logic [c_CNT_W-1:0] c_BIT_LAST  = c_CNT_W'(c_CLKS_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0] c_STOP_LAST = c_CNT_W'(c_STOP_CLKS - 1);
    localparam logic [c_BIT_W-1:0] c_DATA_LAST = c_BIT_W'(DATA_BITS - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST  = c_IDX_W'(MSG_LEN - 1);
    localparam logic [7:0]         c_DATA_MASK = 8'((1 << DATA_BITS) - 1);
    localparam logic               c_ODD       = (PARITY == 2);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_PAR   = 3'd3,
        S_STOP  = 3'd4,
        S_NEXT  = 3'd5
    } state_t;

    state_t               r_state, w_state_nx;
    logic [c_CNT_W-1:0]   r_cnt, w_cnt_nx;
    logic [c_BIT_W-1:0]   r_bit, w_bit_nx;
    logic [c_IDX_W-1:0]   r_idx, w_idx_nx;
    logic                 r_busy, w_busy_nx;
    logic                 r_done, w_done_nx;
    logic                 r_tx, w_tx_nx;
    logic                 w_bit_end;
    logic [7:0]           w_char;

    logic                 r_sync1, r_sync2, r_edge_prev, r_armed;
    logic [1:0]           r_fill;
    logic                 w_start;

    function automatic logic [7:0] char_at(input logic [c_IDX_W-1:0] idx);
        logic [7:0] c;
        c = 8'h00;
        for (int k = 0; k < MSG_LEN; k++) begin
            if (idx == c_IDX_W'(k)) c = MSG[(MSG_LEN-1-k)*8 +: 8];
        end
        return c;
    endfunction

    // r_armed blocks a start until button has been seen low after reset,
    // so a button already held at release cannot fire.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sync1     <= 1'b0;
            r_sync2     <= 1'b0;
            r_edge_prev <= 1'b0;
            r_fill      <= 2'b00;
            r_armed     <= 1'b0;
        end else begin
            r_sync1     <= button;
            r_sync2     <= r_sync1;
            r_edge_prev <= r_sync2;
            r_fill      <= {r_fill[0], 1'b1};
            r_armed     <= r_armed | (r_fill[1] & ~r_sync2);
        end
    end

    assign w_start = r_sync2 & ~r_edge_prev & r_armed;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_idx   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_bit   <= w_bit_nx;
            r_idx   <= w_idx_nx;
            r_busy  <= w_busy_nx;
            r_done  <= w_done_nx;
            r_tx    <= w_tx_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt + 1'b1;
        w_bit_nx   = r_bit;
        w_idx_nx   = r_idx;
        w_busy_nx  = r_busy;
        w_done_nx  = 1'b0;
        w_bit_end  = (r_cnt == c_BIT_LAST);

        case (r_state)
            S_IDLE: begin
                w_cnt_nx = '0;
                if (w_start) begin
                    w_state_nx = S_START;
                    w_idx_nx   = '0;
                    w_busy_nx  = 1'b1;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_state_nx = S_DATA;
                    w_cnt_nx   = '0;
                    w_bit_nx   = '0;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_cnt_nx = '0;
                    if (r_bit == c_DATA_LAST) begin
                        w_state_nx = (PARITY != 0) ? S_PAR : S_STOP;
                    end else begin
                        w_bit_nx = r_bit + 1'b1;
                    end
                end
            end
            S_PAR: begin
                if (w_bit_end) begin
                    w_state_nx = S_STOP;
                    w_cnt_nx   = '0;
                end
            end
            S_STOP: begin
                if (r_cnt == c_STOP_LAST) begin
                    w_state_nx = S_NEXT;
                    w_cnt_nx   = '0;
                    w_done_nx  = (r_idx == c_IDX_LAST);
                end
            end
            S_NEXT: begin
                w_cnt_nx = '0;
                if (r_idx != c_IDX_LAST) begin
                    w_idx_nx   = r_idx + 1'b1;
                    w_state_nx = S_START;
                end else if (repeat_en) begin
                    w_idx_nx   = '0;
                    w_state_nx = S_START;
                end else begin
                    w_state_nx = S_IDLE;
                    w_busy_nx  = 1'b0;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
                w_cnt_nx   = '0;
                w_busy_nx  = 1'b0;
            end
        endcase

        // tx is computed from the next state so the line changes exactly on
        // the state-entry edge and comes straight out of a flop.
        w_char  = char_at(w_idx_nx) & c_DATA_MASK;
        w_tx_nx = 1'b1;
        case (w_state_nx)
            S_START: w_tx_nx = 1'b0;
            S_DATA:  w_tx_nx = w_char[w_bit_nx];
            S_PAR:   w_tx_nx = (^w_char) ^ c_ODD;
            default: w_tx_nx = 1'b1;
        endcase
    end

    assign tx       = r_tx;
    assign busy     = r_busy;
    assign done     = r_done;
    assign char_idx = r_idx;

endmodule
`default_nettype wire
